prbs_burst_sched: RTL

- Sequences the QPSK test-pattern PRBS generators: seeds them, then issues symbol-rate enable strobes for a programmed burst of symbols.
- Drives the generators' active-low reset and enable; the I and Q instances share these outputs.
- Sits between the TX control registers and the PRBS/mapper datapath; one enable per symbol period of SPS clocks.

---
 rtl/prbs_burst_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/prbs_burst_sched.sv
// Burst scheduler for the QPSK test-pattern PRBS generators: seeds them, then strobes one
// enable per SPS-clock symbol period. Optional macro PRBS_RESUME_EN lets bursts continue the sequence.
module prbs_burst_sched #(
   parameter int SPS   = 4,
   parameter int PHASE = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] burst_len,
   output logic             prbs_rst_n,
   output logic             prbs_enable,
   output logic             sym_strobe,
   output logic [CNT_W-1:0] sym_count,
   output logic             busy,
   output logic             done
);

   localparam int PH_W = $clog2(SPS);

   typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [PH_W-1:0]   phase_p0;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              strobe_p1;
   logic              accept;
   logic              en_p0;
   logic              last_en;
`ifdef PRBS_RESUME_EN
   logic              seeded;
`endif

   // The count never wraps; the largest burst length is the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign accept  = (state == IDLE) && start && !abort;
   assign en_p0   = (state == RUN) && (phase_p0 == PH_W'(PHASE));
   assign last_en = en_p0 && (sat_inc(cnt_q) == len_q);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef PRBS_RESUME_EN
               if (seeded)
                  state_nxt = (burst_len == '0) ? DONE : RUN;
               else
                  state_nxt = SEED;
`else
               state_nxt = SEED;
`endif
            end
         end
         SEED: begin
            if (abort)
               state_nxt = IDLE;
            else
               state_nxt = (len_q == '0) ? DONE : RUN;
         end
         RUN: begin
            if (abort)
               state_nxt = IDLE;
            else if (last_en)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: state, symbol phase, burst length and count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         phase_p0 <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state <= state_nxt;
         if ((state == RUN) && (state_nxt == RUN))
            phase_p0 <= (phase_p0 == PH_W'(SPS - 1)) ? '0 : phase_p0 + PH_W'(1);
         else
            phase_p0 <= '0;
         if (accept) begin
            len_q <= burst_len;
            cnt_q <= '0;
         end else if (en_p0) begin
            cnt_q <= sat_inc(cnt_q);
         end
      end
   end

   // Stage p1: generator output bit valid one clock after the enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         strobe_p1 <= 1'b0;
      else
         strobe_p1 <= en_p0;
   end

`ifdef PRBS_RESUME_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seeded <= 1'b0;
      else if (abort)
         seeded <= 1'b0;
      else if (state == SEED)
         seeded <= 1'b1;
   end

   // Generator stays out of reset between bursts once seeded, so the sequence continues.
   assign prbs_rst_n = seeded && (state != SEED);
`else
   assign prbs_rst_n = (state == RUN) || (state == DONE);
`endif

   assign prbs_enable = en_p0;
   assign sym_strobe  = strobe_p1;
   assign sym_count   = cnt_q;
   assign busy        = (state == SEED) || (state == RUN);
   assign done        = (state == DONE);

endmodule
